// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with configurable width/depth, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// choice of registered (1-cycle latency) or first-word-fall-through reads.
module sync_fifo_param #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int AFULL_THR  = DEPTH - 2,
    parameter int AEMPTY_THR = 2,
    parameter int SHOW_AHEAD = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          data_out,
    output logic                       data_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              wr_acc, rd_acc;

    // Acceptance uses the registered flags so a write is refused when full
    // even if a read is popping in the same cycle.
    always_comb begin
        wr_acc   = wr_en && !full_q;
        rd_acc   = rd_en && !empty_q;
        wr_ptr_d = wr_ptr_q + CW'(wr_acc);
        rd_ptr_d = rd_ptr_q + CW'(rd_acc);
        // Extra pointer bit makes the difference the exact occupancy 0..DEPTH.
        count_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CW'(AFULL_THR));
        aempty_d = (count_d <= CW'(AEMPTY_THR));
        // A new error event wins over a coincident clear.
        ovf_d    = (ovf_q && !clr_err) || (wr_en && full_q);
        udf_d    = (udf_q && !clr_err) || (rd_en && empty_q);
    end

    // Pointer, occupancy, status and error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
    end

    generate
        if (SHOW_AHEAD == 0) begin : g_std
            logic [DATA_W-1:0] dout_q;
            logic              dv_q;

            // Registered read: word appears the cycle after its rd_acc, held otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q <= '0;
                    dv_q   <= 1'b0;
                end else begin
                    dv_q <= rd_acc;
                    if (rd_acc) dout_q <= mem_q[rd_ptr_q[AW-1:0]];
                end
            end

            assign data_out   = dout_q;
            assign data_valid = dv_q;
        end else begin : g_fwft
            // Head word is presented whenever the FIFO holds data; rd_en pops it.
            assign data_out   = empty_q ? '0 : mem_q[rd_ptr_q[AW-1:0]];
            assign data_valid = !empty_q;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
endmodule
